// File: rtl/rf_scoreboard_pkg.sv
// Shared decode-stage definitions: register file geometry, scoreboard sizing
// and the stall-reason encoding consumed by the perf counters.
package rf_scoreboard_pkg;
  localparam int RF_AWIDTH = 5;
  localparam int RF_DEPTH  = 1 << RF_AWIDTH;
  localparam int SB_CNT_W  = 2;
  // Sized to hold every counter saturated at once, so the total never wraps.
  localparam int SB_TOT_W  = $clog2((RF_DEPTH - 1) * ((1 << SB_CNT_W) - 1) + 1);

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_RS1  = 2'd1,
    STALL_RS2  = 2'd2,
    STALL_SAT  = 2'd3
  } stall_rsn_e;

  function automatic stall_rsn_e stall_rsn(input logic hz1, input logic hz2, input logic sat);
    if (hz1)      return STALL_RS1;
    else if (hz2) return STALL_RS2;
    else if (sat) return STALL_SAT;
    else          return STALL_NONE;
  endfunction
endpackage

// File: rtl/sb_cnt.sv
// One register's pending-write counter: saturating up/down with clear,
// nonzero/saturated status and an underflow flag for a decrement at zero.
module sb_cnt
  import rf_scoreboard_pkg::*;
#(
  parameter int W = SB_CNT_W
) (
  input  logic gclk_i,
  input  logic grst_n_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic nz_o,
  output logic sat_o,
  output logic unf_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign nz_o  = (cnt_q != '0);
  assign sat_o = &cnt_q;
  assign unf_o = dec_i & ~nz_o;

  // A decrement at zero is dropped, so inc+dec from zero still nets +1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else begin
      unique case ({inc_i & ~sat_o, dec_i & nz_o})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge gclk_i) begin
    if (!grst_n_i) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rf_scoreboard.sv
// Register-file scoreboard and issue interlock: per-register pending-write
// counters, RAW/saturation stall, total outstanding count and sticky error.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W,
  parameter int TOT_W = SB_TOT_W
) (
  input  logic                 gclk_i,
  input  logic                 grst_n_i,
  input  logic                 id_valid_i,
  input  logic [RF_AWIDTH-1:0] rs1_addr_i,
  input  logic                 rs1_use_i,
  input  logic [RF_AWIDTH-1:0] rs2_addr_i,
  input  logic                 rs2_use_i,
  input  logic [RF_AWIDTH-1:0] rd_addr_i,
  input  logic                 rd_wen_i,
  input  logic                 wb_valid_i,
  input  logic [RF_AWIDTH-1:0] wb_addr_i,
  input  logic                 flush_i,
  output logic                 id_stall_o,
  output logic                 issue_o,
  output logic [RF_DEPTH-1:0]  busy_vec_o,
  output logic [TOT_W-1:0]     outstanding_o,
  output logic                 sb_err_o
);
  logic [RF_DEPTH-1:0] busy, sat_v, unf_v;
  logic                hz1, hz2, sat, do_inc, do_dec, dec_eff, unf;
  stall_rsn_e          rsn;
  logic [TOT_W-1:0]    tot_q, tot_d;
  logic                err_q, err_d;

  // x0 has no counter, so it can never be busy, saturated or underflow.
  assign busy[0]  = 1'b0;
  assign sat_v[0] = 1'b0;
  assign unf_v[0] = 1'b0;

  assign hz1        = rs1_use_i & busy[rs1_addr_i];
  assign hz2        = rs2_use_i & busy[rs2_addr_i];
  assign sat        = rd_wen_i & sat_v[rd_addr_i];
  assign rsn        = stall_rsn(hz1, hz2, sat);
  assign id_stall_o = id_valid_i & (rsn != STALL_NONE);
  assign issue_o    = id_valid_i & ~id_stall_o;

  assign do_inc = issue_o & rd_wen_i & (rd_addr_i != '0);
  assign do_dec = wb_valid_i & (wb_addr_i != '0);

  for (genvar r = 1; r < RF_DEPTH; r++) begin : g_cnt
    sb_cnt #(.W(CNT_W)) u_cnt (
      .gclk_i  (gclk_i),
      .grst_n_i(grst_n_i),
      .clr_i   (flush_i),
      .inc_i   (do_inc & (rd_addr_i == RF_AWIDTH'(r))),
      .dec_i   (do_dec & (wb_addr_i == RF_AWIDTH'(r))),
      .nz_o    (busy[r]),
      .sat_o   (sat_v[r]),
      .unf_o   (unf_v[r])
    );
  end

  assign unf     = |unf_v;
  assign dec_eff = do_dec & ~unf;

  always_comb begin
    tot_d = tot_q + TOT_W'(do_inc) - TOT_W'(dec_eff);
    if (flush_i) tot_d = '0;
    err_d = err_q | (unf & ~flush_i);
  end

  always_ff @(posedge gclk_i) begin
    if (!grst_n_i) begin
      tot_q <= '0;
      err_q <= 1'b0;
    end else begin
      tot_q <= tot_d;
      err_q <= err_d;
    end
  end

  assign busy_vec_o    = busy;
  assign outstanding_o = tot_q;
  assign sb_err_o      = err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed, table-driven check of the scoreboard: each row sets decode/wb
// inputs for one cycle and states the outputs expected just before its edge.
module tb_rf_scoreboard;
  import rf_scoreboard_pkg::*;

  localparam int AW = RF_AWIDTH;

  typedef struct {
    logic          rst_n, idv;
    logic [AW-1:0] rs1; logic u1;
    logic [AW-1:0] rs2; logic u2;
    logic [AW-1:0] rd;  logic wen;
    logic          wbv; logic [AW-1:0] wba;
    logic          fl;
    logic          e_stall, e_issue;
    logic [31:0]   e_busy;
    int            e_out;
    logic          e_err;
  } vec_t;

  logic                gclk = 1'b0;
  logic                grst_n, id_valid, rs1_use, rs2_use, rd_wen, wb_valid, flush;
  logic [AW-1:0]       rs1_addr, rs2_addr, rd_addr, wb_addr;
  logic                id_stall, issue, sb_err;
  logic [RF_DEPTH-1:0] busy_vec;
  logic [SB_TOT_W-1:0] outstanding;

  int total = 0;
  int bad   = 0;
  vec_t vt[$];

  rf_scoreboard dut (
    .gclk_i(gclk), .grst_n_i(grst_n), .id_valid_i(id_valid),
    .rs1_addr_i(rs1_addr), .rs1_use_i(rs1_use),
    .rs2_addr_i(rs2_addr), .rs2_use_i(rs2_use),
    .rd_addr_i(rd_addr), .rd_wen_i(rd_wen),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .flush_i(flush),
    .id_stall_o(id_stall), .issue_o(issue), .busy_vec_o(busy_vec),
    .outstanding_o(outstanding), .sb_err_o(sb_err)
  );

  always #5 gclk = ~gclk;

  function automatic vec_t mk(input logic rst_n, idv, input int rs1, u1, rs2, u2,
                              input int rd, wen, wbv, wba, fl,
                              input logic es, ei, input logic [31:0] eb,
                              input int eo, input logic ee);
    vec_t v;
    v.rst_n = rst_n; v.idv = idv;
    v.rs1 = AW'(rs1); v.u1 = u1[0]; v.rs2 = AW'(rs2); v.u2 = u2[0];
    v.rd = AW'(rd); v.wen = wen[0]; v.wbv = wbv[0]; v.wba = AW'(wba); v.fl = fl[0];
    v.e_stall = es; v.e_issue = ei; v.e_busy = eb; v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    grst_n = v.rst_n; id_valid = v.idv;
    rs1_addr = v.rs1; rs1_use = v.u1; rs2_addr = v.rs2; rs2_use = v.u2;
    rd_addr = v.rd; rd_wen = v.wen; wb_valid = v.wbv; wb_addr = v.wba; flush = v.fl;
  endtask

  initial begin
    //          rst idv rs1 u1 rs2 u2 rd wen wbv wba fl  stall issue busy          out err
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  5, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0)); // issue rd5
    vt.push_back(mk(1, 1, 5, 1, 0, 0,  0, 0, 1, 5, 0,  1, 0, 32'h20,       1, 0)); // RAW + wb same cycle
    vt.push_back(mk(1, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0,  0, 1, 32'h0,        0, 0)); // cleared next cycle
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0)); // rd=x0 x4
    vt.push_back(mk(1, 1, 0, 1, 0, 1,  0, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0)); // rd7 x3
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  0, 1, 32'h80,       1, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  0, 1, 32'h80,       2, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  7, 1, 0, 0, 0,  1, 0, 32'h80,       3, 0)); // saturated
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  7, 1, 0, 0, 0,  0, 0, 32'h80,       3, 0)); // no id_valid
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 7, 0,  0, 0, 32'h80,       3, 0)); // drain rd7
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 7, 0,  0, 0, 32'h80,       2, 0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 7, 0,  0, 0, 32'h80,       1, 0));
    vt.push_back(mk(1, 1, 0, 0, 7, 1,  0, 0, 0, 0, 0,  0, 1, 32'h0,        0, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  9, 1, 0, 0, 0,  0, 1, 32'h0,        0, 0)); // pend9=1
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  9, 1, 1, 9, 0,  0, 1, 32'h200,      1, 0)); // issue+wb rd9
    vt.push_back(mk(1, 1, 0, 0, 9, 1,  0, 0, 0, 0, 0,  1, 0, 32'h200,      1, 0)); // rs2 hazard
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  3, 1, 0, 0, 0,  0, 1, 32'h200,      1, 0)); // fill 3,4,12
    vt.push_back(mk(1, 1, 0, 0, 0, 0,  4, 1, 0, 0, 0,  0, 1, 32'h208,      2, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 12, 1, 0, 0, 0,  0, 1, 32'h218,      3, 0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 20, 1, 0, 0, 1,  0, 1, 32'h1218,     4, 0)); // flush + issue
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0,  0, 0, 32'h0,        0, 0)); // wb x0: no error
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 6, 0,  0, 0, 32'h0,        0, 0)); // underflow
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 32'h0,        0, 1)); // flush keeps err
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 1)); // reset clears
    vt.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h0,        0, 0));

    // Reset held two edges with a writeback to r5 pending on the bus.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 32'h0, 0, 0));
    repeat (2) @(posedge gclk);
    #1;
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL reset_busy got=%h want=0", busy_vec); end
    total++; if (outstanding !== '0) begin bad++; $display("FAIL reset_out got=%0d want=0", outstanding); end
    total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", sb_err); end

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      #4;
      total++;
      if (id_stall !== vt[i].e_stall || issue !== vt[i].e_issue ||
          busy_vec !== vt[i].e_busy || outstanding !== SB_TOT_W'(vt[i].e_out) ||
          sb_err !== vt[i].e_err) begin
        bad++;
        $display("FAIL vec%0d got stall=%b issue=%b busy=%h out=%0d err=%b want stall=%b issue=%b busy=%h out=%0d err=%b",
                 i, id_stall, issue, busy_vec, outstanding, sb_err,
                 vt[i].e_stall, vt[i].e_issue, vt[i].e_busy, vt[i].e_out, vt[i].e_err);
      end
      @(posedge gclk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
